// File: rtl/store_narrow.sv
// store_narrow: store-path narrowing unit between execute and a doubleword data memory
// that has no byte enables. Doubleword stores write directly; narrower stores read the
// containing doubleword, merge the new byte lanes in, and write it back.
//
// Optional feature macro: STORE_MISALIGN_TRAP_EN
//   defined   -> misaligned requests complete immediately with o_misaligned=1 and make no
//                memory access
//   undefined -> o_misaligned is absent; address bits below the access alignment are
//                cleared at accept and the store proceeds normally
//
// Ports:
//   i_clk, i_reset             clock, asynchronous active-high reset
//   i_req_valid / o_req_ready  store request handshake (ready only while idle)
//   i_addr, i_data, i_size     byte address, rs2 value, size (00 b, 01 h, 10 w, 11 d)
//   o_done                     one-cycle completion pulse
//   o_misaligned               trap flag, valid with o_done (macro builds only)
//   o_mem_addr                 doubleword-aligned memory address
//   o_mem_rd / i_mem_rdata / i_mem_rvalid   read request, held until rvalid
//   o_mem_wr / o_mem_wdata / i_mem_wack     write request, held until wack
module store_narrow #(
  parameter int unsigned ADDR_W = 64
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [63:0]       i_data,
  input  logic [1:0]        i_size,
  output logic              o_done,
`ifdef STORE_MISALIGN_TRAP_EN
  output logic              o_misaligned,
`endif
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  input  logic [63:0]       i_mem_rdata,
  input  logic              i_mem_rvalid,
  output logic              o_mem_wr,
  output logic [63:0]       o_mem_wdata,
  input  logic              i_mem_wack
);

  localparam logic [1:0] SizeB = 2'b00;
  localparam logic [1:0] SizeH = 2'b01;
  localparam logic [1:0] SizeW = 2'b10;
  localparam logic [1:0] SizeD = 2'b11;

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [2:0]        off_q;
  logic [1:0]        size_q;
  logic [63:0]       data_q;
  logic [63:0]       wdata_q;

  logic [2:0]        acc_off;
  logic [63:0]       mask;
  logic [5:0]        shamt;
  logic [63:0]       merged;

`ifdef STORE_MISALIGN_TRAP_EN
  logic              mis_q;
  logic              req_mis;

  always_comb begin
    req_mis = 1'b0;
    case (i_size)
      SizeH:   req_mis = i_addr[0];
      SizeW:   req_mis = |i_addr[1:0];
      SizeD:   req_mis = |i_addr[2:0];
      default: req_mis = 1'b0;
    endcase
  end
`endif

  // Byte offset within the doubleword with sub-alignment bits cleared. In trap builds a
  // misaligned request never reaches the merge, so clearing is harmless there too.
  always_comb begin
    acc_off = i_addr[2:0];
    case (i_size)
      SizeB:   acc_off = i_addr[2:0];
      SizeH:   acc_off = {i_addr[2:1], 1'b0};
      SizeW:   acc_off = {i_addr[2], 2'b00};
      default: acc_off = 3'b000;
    endcase
  end

  // Merge the narrowed store value into the doubleword returned by the read.
  always_comb begin
    mask = '1;
    case (size_q)
      SizeB:   mask = 64'h0000_0000_0000_00FF;
      SizeH:   mask = 64'h0000_0000_0000_FFFF;
      SizeW:   mask = 64'h0000_0000_FFFF_FFFF;
      default: mask = '1;
    endcase
    shamt  = {off_q, 3'b000};
    merged = (i_mem_rdata & ~(mask << shamt)) | ((data_q & mask) << shamt);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= StIdle;
      mem_addr_q <= '0;
      off_q      <= '0;
      size_q     <= '0;
      data_q     <= '0;
      wdata_q    <= '0;
`ifdef STORE_MISALIGN_TRAP_EN
      mis_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (i_req_valid) begin
            mem_addr_q <= {i_addr[ADDR_W-1:3], 3'b000};
            off_q      <= acc_off;
            size_q     <= i_size;
            data_q     <= i_data;
`ifdef STORE_MISALIGN_TRAP_EN
            mis_q      <= req_mis;
            if (req_mis) begin
              state_q <= StDone;
            end else
`endif
            if (i_size == SizeD) begin
              // Full doubleword: nothing to preserve, skip the read.
              wdata_q <= i_data;
              state_q <= StWrite;
            end else begin
              state_q <= StRead;
            end
          end
        end
        StRead: begin
          if (i_mem_rvalid) begin
            wdata_q <= merged;
            state_q <= StWrite;
          end
        end
        StWrite: begin
          if (i_mem_wack) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Outputs decode directly from registered state, so reset drops them asynchronously.
  assign o_req_ready = (state_q == StIdle);
  assign o_mem_rd    = (state_q == StRead);
  assign o_mem_wr    = (state_q == StWrite);
  assign o_done      = (state_q == StDone);
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = wdata_q;
`ifdef STORE_MISALIGN_TRAP_EN
  assign o_misaligned = (state_q == StDone) && mis_q;
`endif

endmodule

// File: tb/tb_store_narrow.sv
// tb_store_narrow: directed-vector bench for store_narrow. Each store is stepped cycle by
// cycle with the memory responses driven inline, so every wait is a fixed cycle count.
module tb_store_narrow;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] addr;
  logic [63:0] data;
  logic [1:0]  size;
  logic        done;
  logic        misaligned;
  logic [63:0] mem_addr;
  logic        mem_rd;
  logic [63:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_wr;
  logic [63:0] mem_wdata;
  logic        mem_wack;

  int n_vec = 0;
  int n_err = 0;

  store_narrow #(.ADDR_W(64)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_addr       (addr),
    .i_data       (data),
    .i_size       (size),
    .o_done       (done),
`ifdef STORE_MISALIGN_TRAP_EN
    .o_misaligned (misaligned),
`endif
    .o_mem_addr   (mem_addr),
    .o_mem_rd     (mem_rd),
    .i_mem_rdata  (mem_rdata),
    .i_mem_rvalid (mem_rvalid),
    .o_mem_wr     (mem_wr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_wack   (mem_wack)
  );

`ifndef STORE_MISALIGN_TRAP_EN
  assign misaligned = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete store. rdelay = idle READ cycles before rvalid; do_read=0 for sd.
  task automatic run_store(input string tag, input logic [63:0] a, input logic [63:0] d,
                           input logic [1:0] s, input bit do_read, input int rdelay,
                           input logic [63:0] rdata, input logic [63:0] exp_addr,
                           input logic [63:0] exp_wdata);
    check({tag, " ready"}, {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    addr      = a;
    data      = d;
    size      = s;
    tick();
    // Scramble the request inputs: the block must have captured them at accept.
    req_valid = 1'b0;
    addr      = 64'hFFFF_FFFF_FFFF_FFFF;
    data      = 64'h5A5A_5A5A_5A5A_5A5A;
    size      = 2'b00;
    if (do_read) begin
      for (int i = 0; i < rdelay; i++) begin
        check({tag, " rd held"}, {63'd0, mem_rd}, 64'd1);
        tick();
      end
      check({tag, " rd"}, {63'd0, mem_rd}, 64'd1);
      check({tag, " rd addr"}, mem_addr, exp_addr);
      check({tag, " no wr in read"}, {63'd0, mem_wr}, 64'd0);
      mem_rdata  = rdata;
      mem_rvalid = 1'b1;
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = 64'h0;
    end
    check({tag, " wr"}, {63'd0, mem_wr}, 64'd1);
    check({tag, " no rd in write"}, {63'd0, mem_rd}, 64'd0);
    check({tag, " wr addr"}, mem_addr, exp_addr);
    check({tag, " wdata"}, mem_wdata, exp_wdata);
    mem_wack = 1'b1;
    tick();
    mem_wack = 1'b0;
    check({tag, " done"}, {63'd0, done}, 64'd1);
    check({tag, " misaligned"}, {63'd0, misaligned}, 64'd0);
    check({tag, " wr dropped"}, {63'd0, mem_wr}, 64'd0);
    tick();
    check({tag, " done pulse"}, {63'd0, done}, 64'd0);
    check({tag, " idle"}, {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    addr       = '0;
    data       = '0;
    size       = '0;
    mem_rdata  = '0;
    mem_rvalid = 1'b0;
    mem_wack   = 1'b0;
    tick();
    tick();
    check("reset ready", {63'd0, req_ready}, 64'd1);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset misaligned", {63'd0, misaligned}, 64'd0);
    check("reset rd", {63'd0, mem_rd}, 64'd0);
    check("reset wr", {63'd0, mem_wr}, 64'd0);
    check("reset mem_addr", mem_addr, 64'd0);
    check("reset wdata", mem_wdata, 64'd0);
    reset = 1'b0;
    tick();

    // Stray responses while idle are ignored.
    mem_rvalid = 1'b1;
    mem_wack   = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    mem_wack   = 1'b0;
    check("stray wr", {63'd0, mem_wr}, 64'd0);
    check("stray done", {63'd0, done}, 64'd0);
    check("stray ready", {63'd0, req_ready}, 64'd1);

    run_store("sd", 64'h10, 64'h1122_3344_5566_7788, 2'b11, 1'b0, 0, 64'h0,
              64'h10, 64'h1122_3344_5566_7788);
    run_store("sb", 64'h13, 64'hFFFF_FFFF_FFFF_FFAB, 2'b00, 1'b1, 0, 64'h0,
              64'h10, 64'h0000_0000_AB00_0000);
    run_store("sh", 64'h16, 64'h0000_0000_0000_BEEF, 2'b01, 1'b1, 0, 64'h1111_1111_1111_1111,
              64'h10, 64'hBEEF_1111_1111_1111);
    run_store("sw stall", 64'h0C, 64'h1234_5678_DEAD_BEEF, 2'b10, 1'b1, 3,
              64'hFFFF_FFFF_FFFF_FFFF, 64'h08, 64'hDEAD_BEEF_FFFF_FFFF);
    run_store("sb lane7", 64'h2F, 64'h0000_0000_0000_0042, 2'b00, 1'b1, 1,
              64'h0123_4567_89AB_CDEF, 64'h28, 64'h4223_4567_89AB_CDEF);

`ifdef STORE_MISALIGN_TRAP_EN
    // Misaligned word: trap completes one cycle after accept with no memory access.
    req_valid = 1'b1;
    addr      = 64'h0A;
    data      = 64'hCAFE_F00D_8765_4321;
    size      = 2'b10;
    tick();
    req_valid = 1'b0;
    check("mis done", {63'd0, done}, 64'd1);
    check("mis flag", {63'd0, misaligned}, 64'd1);
    check("mis no rd", {63'd0, mem_rd}, 64'd0);
    check("mis no wr", {63'd0, mem_wr}, 64'd0);
    tick();
    check("mis done pulse", {63'd0, done}, 64'd0);
    check("mis flag clear", {63'd0, misaligned}, 64'd0);
    check("mis idle", {63'd0, req_ready}, 64'd1);
`else
    // Misaligned word: low address bits forced to zero, lanes [31:0] written.
    run_store("sw mis", 64'h0A, 64'hCAFE_F00D_8765_4321, 2'b10, 1'b1, 0,
              64'hAAAA_AAAA_AAAA_AAAA, 64'h08, 64'hAAAA_AAAA_8765_4321);
    // Misaligned double: forced aligned, still no read.
    run_store("sd mis", 64'h15, 64'h0F0E_0D0C_0B0A_0908, 2'b11, 1'b0, 0, 64'h0,
              64'h10, 64'h0F0E_0D0C_0B0A_0908);
`endif

    // Reset while in READ: rd drops at once, request is lost, late rvalid ignored.
    req_valid = 1'b1;
    addr      = 64'h21;
    data      = 64'h77;
    size      = 2'b00;
    tick();
    req_valid = 1'b0;
    check("rst pre rd", {63'd0, mem_rd}, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst rd async", {63'd0, mem_rd}, 64'd0);
    check("rst ready async", {63'd0, req_ready}, 64'd1);
    check("rst mem_addr", mem_addr, 64'd0);
    tick();
    reset      = 1'b0;
    mem_rdata  = 64'hDEAD_DEAD_DEAD_DEAD;
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("rst no wr", {63'd0, mem_wr}, 64'd0);
      check("rst no done", {63'd0, done}, 64'd0);
      check("rst idle", {63'd0, req_ready}, 64'd1);
      tick();
    end

    // Store after reset recovery still works.
    run_store("post rst sh", 64'h32, 64'h0000_0000_0000_1234, 2'b01, 1'b1, 0, 64'h0,
              64'h30, 64'h0000_0000_1234_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/store_narrow.md
# store_narrow

Store-path counterpart of the load sign-extension logic: takes a 64-bit register value plus a byte address and access size (sb/sh/sw/sd), narrows the value to the requested width and writes it into a doubleword-wide data memory that has no byte enables. Sub-doubleword stores use a read-modify-write sequence. Sits between the execute stage and the data memory port.

## Interface

Parameters:
- ADDR_W, 64, byte-address width.

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  reset, asynchronous, active-high
- i_req_valid  in  1  store request present
- o_req_ready  out  1  block can accept a request (IDLE only)
- i_addr  in  ADDR_W  byte address of store
- i_data  in  64  rs2 value; low bytes are stored
- i_size  in  2  00 byte, 01 half, 10 word, 11 double (funct3[1:0])
- o_done  out  1  one-cycle pulse, store complete
- o_misaligned  out  1  with STORE_MISALIGN_TRAP_EN only; valid with o_done
- o_mem_addr  out  ADDR_W  doubleword address, bits [2:0] always 0
- o_mem_rd  out  1  read request, held until i_mem_rvalid
- i_mem_rdata  in  64  read data
- i_mem_rvalid  in  1  read data valid
- o_mem_wr  out  1  write request, held until i_mem_wack
- o_mem_wdata  out  64  merged write data
- i_mem_wack  in  1  write accepted

## Operation

- States: IDLE, READ, WRITE, DONE.
- IDLE: o_req_ready=1. On i_req_valid&&o_req_ready, register addr, data, size; inputs may change afterwards.
  - size 11 (aligned) -> WRITE with o_mem_wdata = i_data.
  - otherwise -> READ.
- READ: o_mem_rd=1. On i_mem_rvalid, register merged word into o_mem_wdata -> WRITE.
- WRITE: o_mem_wr=1. On i_mem_wack -> DONE.
- DONE: o_done=1 for one cycle -> IDLE.
- Merge: off = addr[2:0]; mask = 0xFF / 0xFFFF / 0xFFFF_FFFF / all-ones by size; wdata = (rdata & ~(mask<<8*off)) | ((data & mask)<<8*off). Bits of i_data above the size are discarded.
- o_mem_addr = {addr[ADDR_W-1:3], 3'b000}, held constant from accept to DONE.
- Misaligned: half with addr[0]!=0, word with addr[1:0]!=0, double with addr[2:0]!=0.
- i_mem_rvalid outside READ and i_mem_wack outside WRITE are ignored.

## Timing

- Reset values: state IDLE, o_req_ready=1, o_done=0, o_misaligned=0, o_mem_rd=0, o_mem_wr=0, o_mem_addr=0, o_mem_wdata=0.
- All outputs are registered/state-decoded; no input-to-output combinational path.
- Accept at cycle 0. Double: o_mem_wr from cycle 1; with wack in cycle 1, o_done in cycle 2, o_req_ready in cycle 3.
- Sub-double: o_mem_rd from cycle 1; with rvalid in cycle 1, o_mem_wr in cycle 2; with wack in cycle 2, o_done in cycle 3, o_req_ready in cycle 4.
- Memory stalls extend READ/WRITE indefinitely; no timeout.
- Reset mid-operation: immediate return to IDLE, o_mem_rd/o_mem_wr drop asynchronously, the request is lost with no o_done; late responses are ignored.
- Back-to-back: a new request may be accepted the cycle after DONE.

## Configuration

- STORE_MISALIGN_TRAP_EN defined: misaligned request is accepted, goes IDLE -> DONE with no memory access; o_done=1 and o_misaligned=1 for that one cycle. o_misaligned=0 on every other o_done.
- Undefined: o_misaligned port absent; address bits below the size alignment are forced to 0 at accept, and the store proceeds normally.

## Test plan

- sd addr 0x10 data 0x1122334455667788, wack immediate -> no o_mem_rd; o_mem_addr 0x10, o_mem_wdata 0x1122334455667788; o_done at cycle 2.
- sb addr 0x13 data 0xFFFFFFFFFFFFFFAB, rdata 0x0 -> read 0x10; write 0x00000000AB000000; o_done at cycle 3.
- sh addr 0x16 data 0xBEEF, rdata 0x1111111111111111 -> write 0xBEEF111111111111.
- sw addr 0x0C data 0x12345678DEADBEEF, rdata all-ones, rvalid delayed 3 cycles -> o_mem_rd held 3 cycles; write addr 0x08 wdata 0xDEADBEEFFFFFFFFF.
- sw addr 0x0A -> with macro: o_done and o_misaligned at cycle 1, no rd/wr; without: store to 0x08, lanes [31:0].
- Reset asserted in READ, stray rvalid afterwards -> o_mem_rd low immediately, o_req_ready=1, no o_mem_wr, no o_done.
